// File: rtl/uart_tx_drain_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_drain_pkg : shared UART state encodings and line constants    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package uart_tx_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // 48 MHz system clock / 115200 baud
  localparam int   UART_CLK_DIV_DEFAULT = 417;
  localparam logic LINE_IDLE            = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_drain_baud_tick.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_drain_baud_tick : bit-period counter with sync clear          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module uart_tx_drain_baud_tick #(
  parameter int CLK_DIV = 417,
  parameter int CNT_SZ  = 9
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_last_tick
);

  localparam logic [CNT_SZ-1:0] c_last_val = CNT_SZ'(CLK_DIV - 1);

  logic [CNT_SZ-1:0] cnt_q;
  logic [CNT_SZ-1:0] cnt_d;

  assign o_last_tick = (cnt_q == c_last_val);

  always_comb begin
    cnt_d = cnt_q + CNT_SZ'(1);
    if (i_clr || o_last_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_drain.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_drain : FWFT-FIFO drained to 8N1 serial; define               |
// | UART_TX_PARITY_EN to add an even-parity bit.            Rev 1.0       |
// +-----------------------------------------------------------------------+
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int DATA_SZ = 8,
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int CNT_SZ  = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_empty,
  input  logic [DATA_SZ-1:0] i_data,
  output logic               o_rd,
  output logic               o_tx,
  output logic               o_busy
);

  localparam int                  c_idx_sz   = (DATA_SZ > 1) ? $clog2(DATA_SZ) : 1;
  localparam logic [c_idx_sz-1:0] c_last_idx = c_idx_sz'(DATA_SZ - 1);

  state_t               state_q;
  state_t               state_d;
  logic [DATA_SZ-1:0]   shift_q;
  logic [DATA_SZ-1:0]   shift_d;
  logic [c_idx_sz-1:0]  idx_q;
  logic [c_idx_sz-1:0]  idx_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 w_last_tick;
  logic                 w_clr;
  logic                 w_rd;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
  logic                 par_d;
`endif

  // Pop only when the line is free: idle, or the final clock of a stop bit.
  assign w_rd   = ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_last_tick))
                  && !i_empty && i_rst_n;
  assign w_clr  = (state_d != state_q) || (state_q == ST_IDLE);
  assign o_rd   = w_rd;
  assign o_tx   = tx_q;
  assign o_busy = (state_q != ST_IDLE);

  uart_tx_drain_baud_tick #(
    .CLK_DIV (CLK_DIV),
    .CNT_SZ  (CNT_SZ)
  ) u_baud_tick (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (w_clr),
    .o_last_tick (w_last_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_rd) state_d = ST_START;
      ST_START:  if (w_last_tick) state_d = ST_DATA;
      ST_DATA: begin
        if (w_last_tick && (idx_q == c_last_idx)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (w_last_tick) state_d = ST_STOP;
`endif
      ST_STOP:   if (w_last_tick) state_d = w_rd ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the next state so it changes with it.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
    if (w_rd) par_d = ^i_data;
`endif
    if (w_rd) shift_d = i_data;
    if ((state_q == ST_START) && w_last_tick) idx_d = '0;
    if ((state_q == ST_DATA) && w_last_tick) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + c_idx_sz'(1);
    end
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = LINE_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_tx_drain : bench for uart_tx_drain with a line-level model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_uart_tx_drain;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_empty;
  logic [7:0] i_data;
  logic       o_rd;
  logic       o_tx;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_tx_drain #(
    .DATA_SZ (8),
    .CLK_DIV (CD),
    .CNT_SZ  (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_empty (i_empty),
    .i_data  (i_data),
    .o_rd    (o_rd),
    .o_tx    (o_tx),
    .o_busy  (o_busy)
  );

  // Model: FIFO contents plus the queue of line levels still to be sent.
  logic [7:0] fifo[$];
  logic       line_q[$];
  logic       cur_tx;
  logic       cur_busy;
  logic       rd_exp;
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic push_frame(input logic [7:0] b);
    for (int c = 0; c < CD; c++) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CD; c++) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CD; c++) line_q.push_back(^b);
`endif
    for (int c = 0; c < CD; c++) line_q.push_back(1'b1);
  endtask

  // Called at a negedge; drives inputs, checks outputs, advances one clock.
  task automatic step();
    i_empty = (fifo.size() == 0);
    i_data  = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
    #1;
    rd_exp = (line_q.size() == 0) && (fifo.size() != 0) && rst_n;
    vectors++;
    assert (o_rd === rd_exp) else begin
      miscompares++;
      $error("FAIL o_rd observed=%b expected=%b t=%0t", o_rd, rd_exp, $time);
    end
    vectors++;
    assert (o_tx === cur_tx) else begin
      miscompares++;
      $error("FAIL o_tx observed=%b expected=%b t=%0t", o_tx, cur_tx, $time);
    end
    vectors++;
    assert (o_busy === cur_busy) else begin
      miscompares++;
      $error("FAIL o_busy observed=%b expected=%b t=%0t", o_busy, cur_busy, $time);
    end
    @(posedge clk);
    if (!rst_n) begin
      line_q.delete();
      cur_tx   = 1'b1;
      cur_busy = 1'b0;
    end else begin
      if (rd_exp) push_frame(fifo.pop_front());
      if (line_q.size() != 0) begin
        cur_tx   = line_q.pop_front();
        cur_busy = 1'b1;
      end else begin
        cur_tx   = 1'b1;
        cur_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst_n    = 1'b0;
    i_empty  = 1'b1;
    i_data   = 8'h00;
    cur_tx   = 1'b1;
    cur_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with a non-empty FIFO, then the single A5 frame.
    fifo.push_back(8'hA5);
    run(5);
    rst_n = 1'b1;
    run(FRAME + 8);

    // Back-to-back frames.
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    run(2 * FRAME + 8);

    // Empty FIFO: line stays idle.
    run(100);

    // Reset during data bit 3, with another byte waiting.
    fifo.push_back(8'($urandom));
    step();
    run(17);
    fifo.push_back(8'($urandom));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(FRAME + 8);

    // Parity-relevant bytes.
    fifo.push_back(8'h07);
    run(FRAME + 4);
    fifo.push_back(8'h03);
    run(FRAME + 4);

    // Random arrivals and gaps.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) != 0) fifo.push_back(8'($urandom));
      run($urandom_range(1, 25));
    end
    run((fifo.size() + 1) * FRAME + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
